// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: request, hold for decode, advance or redirect
// Optional FETCH_MISALIGN_CHECK_EN traps misaligned redirect targets into a sticky error state.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        pc_redirect,
    input  logic [31:0] pc_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] fetch_count,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state;
    logic [31:0] pc;
    logic        req_q;
    logic        valid_q;

    assign imem_req    = req_q;
    assign instr_valid = valid_q;
    assign imem_addr   = pc;
    assign pc_plus4    = instr_pc + 32'd4;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic err_q;
    assign misalign_err = err_q;
`else
    assign misalign_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            instr       <= NOP;
            instr_pc    <= 32'h0000_0000;
            fetch_count <= 32'h0000_0000;
            req_q       <= 1'b1;
            valid_q     <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        fetch_count <= fetch_count + 32'd1;
                        state       <= S_HOLD;
                        req_q       <= 1'b0;
                        valid_q     <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // stall wins over redirect: the instruction is still owned by decode
                    if (!stall) begin
                        valid_q <= 1'b0;
                        if (pc_redirect) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                            if (pc_target[1:0] != 2'b00) begin
                                state <= S_ERR;
                                err_q <= 1'b1;
                            end else begin
                                pc    <= pc_target;
                                state <= S_REQ;
                                req_q <= 1'b1;
                            end
`else
                            pc    <= pc_target & 32'hFFFF_FFFC;
                            state <= S_REQ;
                            req_q <= 1'b1;
`endif
                        end else begin
                            pc    <= pc_plus4;
                            state <= S_REQ;
                            req_q <= 1'b1;
                        end
                    end
                end
                S_ERR: begin
                    state   <= S_ERR;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    state   <= S_REQ;
                    req_q   <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit (directed vectors, RESET_PC=0x100)
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic [31:0] fetch_count;
    logic        misalign_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
        logic [31:0] count;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_count;
    logic        prev_valid = 1'b0;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .pc_redirect (pc_redirect),
        .pc_target   (pc_target),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .pc_plus4    (pc_plus4),
        .fetch_count (fetch_count),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every new delivery (rising instr_valid) must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && instr_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got instr %h with no expectation queued", instr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_instr", instr, e.word);
                chk("sb_instr_pc", instr_pc, e.addr);
                chk("sb_fetch_count", fetch_count, e.count);
            end
        end
        prev_valid = instr_valid;
    end

    // Runs from a negedge in S_REQ; returns at the negedge after the ack edge (S_HOLD)
    task automatic do_fetch(input int waits, input logic [31:0] data, input logic [31:0] addr);
        exp_t e;
        for (int i = 0; i < waits; i++) begin
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, addr);
            imem_ack = 1'b0;
            @(negedge clk);
        end
        chk("ack_req", {31'd0, imem_req}, 32'd1);
        chk("ack_addr", imem_addr, addr);
        imem_ack   = 1'b1;
        imem_rdata = data;
        exp_count  = exp_count + 32'd1;
        e.word = data; e.addr = addr; e.count = exp_count;
        sb.push_back(e);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("hold_pc_plus4", pc_plus4, addr + 32'd4);
    endtask

    task automatic release_hold(input logic redirect, input logic [31:0] target);
        stall       = 1'b0;
        pc_redirect = redirect;
        pc_target   = target;
        @(negedge clk);
        pc_redirect = 1'b0;
        pc_target   = 32'h0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        stall = 1'b0; pc_redirect = 1'b0; pc_target = 32'h0;
        exp_count = 32'd0;
        repeat (2) @(negedge clk);

        // Reset state, with an ack held throughout reset that must be discarded
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd1);
        chk("rst_addr", imem_addr, 32'h100);
        rst = 1'b0;

        // Zero-wait fetch in the first cycle after reset
        do_fetch(0, 32'h0050_0093, 32'h100);

        // Stall 3 cycles with a simultaneous redirect and a spurious ack: all ignored
        stall = 1'b1; pc_redirect = 1'b1; pc_target = 32'h300;
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_instr", instr, 32'h0050_0093);
            chk("stall_instr_pc", instr_pc, 32'h100);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_count", fetch_count, 32'd1);
        end
        imem_ack = 1'b0;
        release_hold(1'b0, 32'h0);
        chk("seq_addr", imem_addr, 32'h104);

        // Four wait states: request held five cycles
        do_fetch(4, 32'h00A0_0113, 32'h104);
        release_hold(1'b1, 32'h200);
        chk("redir_addr", imem_addr, 32'h200);
        do_fetch(0, 32'h0000_0011, 32'h200);

`ifdef FETCH_MISALIGN_CHECK_EN
        release_hold(1'b1, 32'h202);
        imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        for (int i = 0; i < 3; i++) begin
            chk("err_flag", {31'd0, misalign_err}, 32'd1);
            chk("err_valid", {31'd0, instr_valid}, 32'd0);
            chk("err_req", {31'd0, imem_req}, 32'd0);
            chk("err_count", fetch_count, 32'd3);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("err_rst_flag", {31'd0, misalign_err}, 32'd0);
        chk("err_rst_addr", imem_addr, 32'h100);
        rst = 1'b0;
        exp_count = 32'd0;
        do_fetch(0, 32'h0000_0055, 32'h100);
`else
        release_hold(1'b1, 32'h202);
        chk("misalign_addr", imem_addr, 32'h200);
        chk("misalign_flag", {31'd0, misalign_err}, 32'd0);
        do_fetch(0, 32'h0000_0055, 32'h200);
`endif

        // Wrap of pc+4 at the top of the address space
        release_hold(1'b1, 32'hFFFF_FFFC);
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        do_fetch(1, 32'h0000_0033, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4, 32'h0);
        release_hold(1'b0, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        do_fetch(0, 32'h0000_0044, 32'h0);

        @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port imem_req  out  1  instruction memory read request.
REQ-005 SHALL have port imem_addr  out  32  word address of the request; equals pc.
REQ-006 SHALL have port imem_ack  in  1  memory read-data-valid strobe.
REQ-007 SHALL have port imem_rdata  in  32  instruction word, qualified by imem_ack.
REQ-008 SHALL have port stall  in  1  downstream hold request for the presented instruction.
REQ-009 SHALL have port pc_redirect  in  1  taken branch or jump for the presented instruction.
REQ-010 SHALL have port pc_target  in  32  redirect destination.
REQ-011 SHALL have port instr_valid  out  1  instr and instr_pc are valid for decode and immediate extension.
REQ-012 SHALL have port instr  out  32  registered instruction word.
REQ-013 SHALL have port instr_pc  out  32  address of instr.
REQ-014 SHALL have port pc_plus4  out  32  instr_pc + 4, combinational, modulo 2^32.
REQ-015 SHALL have port fetch_count  out  32  count of instructions delivered.
REQ-016 SHALL have port misalign_err  out  1  sticky misaligned-redirect flag.

Function
REQ-017 SHALL implement states S_REQ, S_HOLD and S_ERR, encoded in a state register.
REQ-018 In S_REQ: imem_req=1, instr_valid=0; imem_ack is sampled every cycle, including the first cycle of S_REQ (zero-wait memory allowed).
REQ-019 On imem_ack in S_REQ: instr<=imem_rdata, instr_pc<=pc, fetch_count<=fetch_count+1 (wraps at 2^32), next state S_HOLD.
REQ-020 In S_HOLD: imem_req=0, instr_valid=1; instr and instr_pc are stable.
REQ-021 S_HOLD with stall=1 SHALL remain in S_HOLD; pc_redirect is ignored in this cycle (stall has priority).
REQ-022 S_HOLD with stall=0 SHALL set pc<=pc_target if pc_redirect=1, else pc<=instr_pc+4, and go to S_REQ.
REQ-023 Throughput SHALL be one instruction per 2 cycles with zero-wait memory; ack-to-instr_valid latency is 1 cycle.
REQ-024 imem_ack outside S_REQ SHALL be ignored, with no state change.
REQ-025 pc_redirect and pc_target outside S_HOLD SHALL be ignored.
REQ-026 pc+4 SHALL wrap 32'hFFFF_FFFC to 32'h0000_0000.
REQ-027 In S_ERR: imem_req=0, instr_valid=0, misalign_err=1; the block SHALL stay in S_ERR until rst.

Reset
REQ-028 On rst=1 at a clock edge: state=S_REQ, pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_pc=0, instr_valid=0, fetch_count=0, misalign_err=0.
REQ-029 Reset SHALL override any in-flight request; an imem_ack in the reset cycle SHALL be discarded.
REQ-030 In the first cycle after reset, imem_req=1 and imem_addr=RESET_PC.

Configuration
REQ-031 Macro FETCH_MISALIGN_CHECK_EN, when defined: a redirect accepted per REQ-022 with pc_target[1:0]!=2'b00 SHALL go to S_ERR instead of S_REQ, set misalign_err, and leave pc unchanged.
REQ-032 When FETCH_MISALIGN_CHECK_EN is undefined: a redirect SHALL load {pc_target[31:2],2'b00}, S_ERR SHALL be unreachable, and misalign_err SHALL be held at constant 0.

Verification
REQ-033 Reset release with RESET_PC=32'h100 and ack in the same cycle as req, rdata=32'h00500093 -> next cycle instr_valid=1, instr=32'h00500093, instr_pc=32'h100, pc_plus4=32'h104, fetch_count=1.
REQ-034 Stall=1 held for 3 cycles in S_HOLD -> instr and instr_pc unchanged and imem_req=0 throughout; then stall=0 -> next imem_addr=instr_pc+4.
REQ-035 pc_redirect=1 with pc_target=32'h200 and stall=0 in S_HOLD -> next cycle imem_addr=32'h200; with stall=1 in the same cycle -> redirect ignored.
REQ-036 Memory acks after 4 wait cycles -> imem_req high for 5 cycles, then instr_valid=1; a spurious ack during S_HOLD -> instr unchanged.
REQ-037 With the macro defined, redirect to 32'h202 -> misalign_err=1, instr_valid=0, no further requests until rst; with the macro undefined -> imem_addr=32'h200, misalign_err=0.
REQ-038 Redirect to 32'hFFFF_FFFC followed by a fetch -> next imem_addr=32'h0000_0000 (wrap).
